// File: rtl/debug_pkg.sv
// Shared debug-port definitions: command codes, header field positions and
// the loader FSM state encoding (also used by the read-back path).
package debug_pkg;

  localparam int HDR_CMD_MSB = 7;
  localparam int HDR_CMD_LSB = 4;
  localparam int HDR_LEN_MSB = 3;
  localparam int HDR_LEN_LSB = 0;

  localparam logic [3:0] CMD_CLR_ERR = 4'h0;
  localparam logic [3:0] CMD_DMEM_WR = 4'h1;
  localparam logic [3:0] CMD_REG_WR  = 4'h2;
  localparam logic [3:0] CMD_HALT    = 4'h8;
  localparam logic [3:0] CMD_RUN     = 4'h9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_WRITE = 2'd3
  } dbg_state_e;

  function automatic logic is_wr_cmd(input logic [3:0] cmd);
    return (cmd == CMD_DMEM_WR) || (cmd == CMD_REG_WR);
  endfunction

endpackage

// File: rtl/debug_din_unit.sv
// Host-to-core debug loader: parses header/address/data packets from the
// host byte stream and drives halt control plus dmem/regfile write strobes.
module debug_din_unit #(
  parameter int ADDR_W = 8,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        din_data,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              cpu_halt,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [7:0]        dmem_wdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [7:0]        rf_wdata,
  output logic              busy,
  output logic              err
);
  import debug_pkg::*;

  dbg_state_e        state, state_nxt;
  logic              accept;
  logic [3:0]        hdr_cmd;
  logic [3:0]        remain;
  logic              tgt_reg;
  logic              wr_ok;
  logic [ADDR_W-1:0] addr;

  assign accept  = din_valid && din_ready;
  assign hdr_cmd = din_data[HDR_CMD_MSB:HDR_CMD_LSB];
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept && is_wr_cmd(hdr_cmd)) state_nxt = ST_ADDR;
      ST_ADDR:  if (accept) state_nxt = ST_DATA;
      ST_DATA:  if (accept) state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = (remain == 4'd0) ? ST_IDLE : ST_DATA;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Strobe, address and data are registered on the DATA accept so they are
  // valid throughout the WRITE cycle and hold afterwards while addr advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_ready  <= 1'b0;
      cpu_halt   <= 1'b0;
      err        <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      remain     <= '0;
      tgt_reg    <= 1'b0;
      wr_ok      <= 1'b0;
      addr       <= '0;
    end else begin
      din_ready <= (state_nxt != ST_WRITE);
      dmem_we   <= 1'b0;
      rf_we     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (hdr_cmd)
              CMD_DMEM_WR, CMD_REG_WR: begin
                tgt_reg <= (hdr_cmd == CMD_REG_WR);
                remain  <= din_data[HDR_LEN_MSB:HDR_LEN_LSB];
                wr_ok   <= cpu_halt;
                if (!cpu_halt) err <= 1'b1;
              end
              CMD_HALT:    cpu_halt <= 1'b1;
              CMD_RUN:     cpu_halt <= 1'b0;
              CMD_CLR_ERR: err      <= 1'b0;
              default:     err      <= 1'b1;
            endcase
          end
        end
        ST_ADDR: begin
          if (accept) addr <= ADDR_W'(din_data);
        end
        ST_DATA: begin
          if (accept && wr_ok) begin
            if (tgt_reg) begin
              rf_we    <= 1'b1;
              rf_waddr <= addr[REG_AW-1:0];
              rf_wdata <= din_data;
            end else begin
              dmem_we    <= 1'b1;
              dmem_addr  <= addr;
              dmem_wdata <= din_data;
            end
          end
        end
        ST_WRITE: begin
          addr   <= addr + ADDR_W'(1);
          remain <= remain - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/debug_din_unit.md
# debug_din_unit

Host-to-core debug loader: the write-side counterpart of the debug read-back path. Accepts a byte stream from the debug host over a valid/ready handshake, decodes short command packets, and issues halt/run control and write bursts into data RAM and the register file. Sits between the debug port pins and the mini-CPU's `dmem` and `regfile` write ports. Its writes are muxed ahead of the core's own write ports while `cpu_halt` is high.

## Interface
Parameters:
- `ADDR_W`, 8: data RAM address width.
- `REG_AW`, 2: register-file address width.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `din_data` in 8: host byte.
- `din_valid` in 1: host byte valid.
- `din_ready` out 1: unit can accept a byte.
- `cpu_halt` out 1: core frozen; debug owns the write ports.
- `dmem_we` out 1: RAM write strobe.
- `dmem_addr` out ADDR_W: RAM write address.
- `dmem_wdata` out 8: RAM write data.
- `rf_we` out 1: register-file write strobe.
- `rf_waddr` out REG_AW: register-file write address.
- `rf_wdata` out 8: register-file write data.
- `busy` out 1: a packet is in progress.
- `err` out 1: sticky protocol error.

## Operation
- Accept occurs on any cycle where `din_valid && din_ready`. Bytes with `din_valid` high and `din_ready` low are not consumed; the host holds them.
- Header byte format:
  - `[7:4]` is the command.
  - `[3:0]` is LEN-1, giving 1..16 payload bytes for write commands and ignored otherwise.
- Commands:
  - `0x1 DMEM_WR`: header, then start address byte, then LEN data bytes to consecutive RAM addresses.
  - `0x2 REG_WR`: header, then address byte (low REG_AW bits used), then LEN data bytes to consecutive registers.
  - `0x8 HALT`: sets `cpu_halt`.
  - `0x9 RUN`: clears `cpu_halt`.
  - `0x0 CLR_ERR`: clears `err`.
  - Any other command sets `err`. The header is dropped and the FSM stays in IDLE.
- FSM states: IDLE, ADDR, DATA, WRITE.
  - IDLE: on a write header, latch cmd and LEN and go to ADDR. Single-byte commands take effect and the FSM stays in IDLE.
  - ADDR: on accept, latch address and go to DATA.
  - DATA: on accept, latch the byte and go to WRITE.
  - WRITE: assert exactly one strobe for one cycle, increment the address and decrement the remaining count. Go to DATA if bytes remain, else IDLE.
- Address arithmetic is modulo 2^ADDR_W (RAM) or 2^REG_AW (register file). 0xFF+1 wraps to 0x00; register 3+1 wraps to 0.
- A write command received while `cpu_halt`=0:
  - sets `err`;
  - the full packet (address and LEN bytes) is still consumed to keep framing;
  - no strobe is issued.
- HALT while already halted, and RUN while already running, have no effect and are not errors.
- `din_ready` is 0 in WRITE and 1 in IDLE, ADDR and DATA.

## Timing
- Reset values: all outputs are 0, including `din_ready`, `cpu_halt` and `err`. `din_ready` goes to 1 on the first clock edge after `rst` falls.
- Data byte accepted at cycle t:
  - `dmem_we`/`rf_we` is high during t+1, with matching address and data;
  - `din_ready` is low during t+1;
  - the next accept is possible at t+2, so throughput is 1 byte per 2 cycles.
- HALT/RUN accepted at t: `cpu_halt` changes at t+1.
- Unknown command accepted at t: `err`=1 at t+1.
- `busy` goes high at t+1 after a write header accept at t. It falls in the cycle after the final WRITE cycle, i.e. when the FSM returns to IDLE.
- Address and data outputs hold their last value when no strobe is active.
- Reset asserted mid-packet:
  - the packet is aborted, with no strobe in the following cycle;
  - all state and outputs are cleared and `cpu_halt` drops;
  - the next byte after reset is parsed as a header.

## Structure
- Shared package `debug_pkg` holds:
  - command codes (`CMD_DMEM_WR`, `CMD_REG_WR`, `CMD_HALT`, `CMD_RUN`, `CMD_CLR_ERR`);
  - the FSM state encoding (2 bits);
  - the header field positions.
- The same package is reused by the debug read-back path.
- Single module. No sub-module is warranted; the FSM, address counter and length counter stay together.

## Test plan
- Halt then RAM burst:
  - stimulus: bytes 0x80, 0x12, 0x10, 0xAA, 0xBB, 0xCC;
  - response: `cpu_halt`=1, then `dmem_we` pulses writing addr 0x10/0xAA, 0x11/0xBB, 0x12/0xCC, each strobe one cycle after its accept;
  - `busy` falls after the last strobe.
- Wrap and register file:
  - stimulus: halted; 0x11, 0xFF, 0x01, 0x02 gives RAM writes 0xFF/0x01 and 0x00/0x02;
  - stimulus: 0x22, 0x03, 0x05, 0x06, 0x07 gives `rf_we` at reg 3/0x05, reg 0/0x06, reg 1/0x07.
- Write while running:
  - stimulus: 0x11, 0x20, 0x55, 0x66, with `cpu_halt`=0;
  - response: `err`=1, no strobes, all 4 bytes accepted;
  - then 0x00 clears `err`.
- Backpressure and idle host:
  - `din_valid` toggled randomly and held high across WRITE cycles;
  - response: no byte is lost or duplicated, and `din_ready` is low exactly in WRITE cycles.
- Unknown command and reset mid-burst:
  - stimulus: 0x50 gives `err`=1 with FSM in IDLE;
  - stimulus: halted, 0x13, 0x40, 0x01, then `rst` pulsed;
  - response: no further strobe, all outputs 0;
  - response: the next 0x80 is decoded as a header.
